// File: rtl/mem_dump_engine.sv
// Sequential read-out engine for memory port B: walks a contiguous word range after a start
// pulse and presents each word with its address on a valid/ready stream.
module mem_dump_engine #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   num_words_i,
   output logic              mem_enb_o,
   output logic              mem_web_o,
   output logic [ADDR_W-1:0] mem_addrb_o,
   input  logic [DATA_W-1:0] mem_doutb_i,
   output logic              dump_valid_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [ADDR_W-1:0] dump_addr_o,
   input  logic              dump_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StCap,
      StHold,
      StDone
   } state_e;

   localparam logic [ADDR_W:0]   RemOne  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic [DATA_W-1:0]   dump_data_q, dump_data_d;
   logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
   logic                dump_valid_q, dump_valid_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         cur_addr_q   <= '0;
         remaining_q  <= '0;
         dump_data_q  <= '0;
         dump_addr_q  <= '0;
         dump_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         remaining_q  <= remaining_d;
         dump_data_q  <= dump_data_d;
         dump_addr_q  <= dump_addr_d;
         dump_valid_q <= dump_valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      remaining_d  = remaining_q;
      dump_data_d  = dump_data_q;
      dump_addr_d  = dump_addr_q;
      dump_valid_d = dump_valid_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (num_words_i != '0) begin
                  cur_addr_d  = base_addr_i;
                  remaining_d = num_words_i;
                  state_d     = StReq;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StReq: state_d = StCap;
         StCap: begin
            // Read data from the REQ cycle is valid on port B now.
            dump_data_d  = mem_doutb_i;
            dump_addr_d  = cur_addr_q;
            dump_valid_d = 1'b1;
            state_d      = StHold;
         end
         StHold: begin
            if (dump_ready_i) begin
               dump_valid_d = 1'b0;
               remaining_d  = remaining_q - RemOne;
               cur_addr_d   = cur_addr_q + AddrOne;
               state_d      = (remaining_q == RemOne) ? StDone : StReq;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign mem_enb_o    = (state_q == StReq);
   assign mem_web_o    = 1'b0;
   assign mem_addrb_o  = cur_addr_q;
   assign dump_valid_o = dump_valid_q;
   assign dump_data_o  = dump_data_q;
   assign dump_addr_o  = dump_addr_q;
   assign busy_o       = (state_q == StReq) || (state_q == StCap) || (state_q == StHold);
   assign done_o       = (state_q == StDone);

endmodule

// File: doc/mem_dump_engine.md
# mem_dump_engine

Sequential read-out engine for the 64-bit unified memory's secondary port (port B). After the core's cache flush has written back all dirty lines, a single `start` pulse makes this block walk a contiguous address range. It issues one read per word and presents each word with its address on a valid/ready stream. The stream feeds the memory-dump consumer in simulation, or a debug/UART drain in hardware. The block is the sole driver of the port-B signals (enb/web/addrb) and consumes doutb.

## Interface
Parameters:
- `ADDR_W`, 14, port-B word address width.
- `DATA_W`, 64, port-B data width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; captured on an accepted `start`.
- `num_words`  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; captured on an accepted `start`.
- `mem_enb`  out  1  port-B enable.
- `mem_web`  out  1  port-B write enable; tied to 0.
- `mem_addrb`  out  ADDR_W  port-B address.
- `mem_doutb`  in  DATA_W  port-B read data; valid exactly one cycle after `mem_enb`.
- `dump_valid`  out  1  a word is presented.
- `dump_data`  out  DATA_W  presented word.
- `dump_addr`  out  ADDR_W  address of the presented word.
- `dump_ready`  in  1  consumer accepts the word when high together with `dump_valid`.
- `busy`  out  1  a dump is in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, REQ, CAP, HOLD, DONE.
- **IDLE**
  - `start`=1 with `num_words`≠0: latch `cur_addr`←`base_addr` and `remaining`←`num_words`, then go to REQ.
  - `start`=1 with `num_words`=0: go directly to DONE.
  - Otherwise stay in IDLE.
- **REQ:** `mem_enb`=1, `mem_addrb`=`cur_addr`; go to CAP.
- **CAP:** register `mem_doutb` into `dump_data` and `cur_addr` into `dump_addr`; set `dump_valid`; go to HOLD.
- **HOLD:** hold `dump_valid`, `dump_data` and `dump_addr` stable until `dump_ready`=1. On the handshake:
  - clear `dump_valid`;
  - `remaining`←`remaining`−1;
  - `cur_addr`←`cur_addr`+1, modulo 2^ADDR_W (0x3FFF+1 wraps to 0x0000);
  - go to REQ if the new `remaining`≠0, otherwise go to DONE.
- **DONE:** `done`=1 for exactly one cycle; go to IDLE.
- `busy`=1 in REQ, CAP and HOLD; 0 in IDLE and DONE.
- `start` outside IDLE is ignored; `base_addr` and `num_words` are not re-sampled.
- Only one read is outstanding at a time, and `mem_enb` is never asserted outside REQ.
- `mem_web` is constant 0.
- `num_words`=2^ADDR_W dumps the whole memory once, starting at `base_addr`.

## Timing
- Reset, asynchronous: state=IDLE. Every output is 0 (`mem_enb`, `mem_web`, `mem_addrb`, `dump_valid`, `dump_data`, `dump_addr`, `busy`, `done`), and `cur_addr` and `remaining` are 0.
- Reset asserted mid-dump clears `dump_valid` immediately, with no clock edge needed. The dump is abandoned and no `done` is produced.
- All outputs are registered or decoded from the state register. There are no combinational paths from `dump_ready` or `start` to any output.
- `start` sampled at edge T gives:
  - REQ in cycle T+1;
  - CAP in T+2, where `mem_doutb` is valid;
  - HOLD in T+3 with `dump_valid`=1.
- A handshake at the end of a HOLD cycle leads to REQ in the next cycle. With `dump_ready` held high, throughput is 1 word per 3 cycles.
- Word k (0-based, `dump_ready` always 1): `dump_valid` is high in cycle T+3+3k.
- The DONE cycle is T+3·N+1 for an N-word dump, or T+1 when N=0.
- Back-pressure only lengthens HOLD. Every later event shifts by the number of stall cycles.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs read 0 before the next edge. Release `rst`, with `start` low for 10 cycles → no `mem_enb`, `busy`=0.
- **Basic dump:** preload words 0x10..0x13 with 0xA000_0000_0000_00{10..13}; pulse `start` at T with base=0x0010, num=4, `dump_ready`=1.
  - Four words appear in cycles T+3, T+6, T+9 and T+12, with `dump_addr` 0x10..0x13 and matching data.
  - `done` is high only in T+13; `mem_enb` fires exactly 4 times.
- **Back-pressure:** base=0x0020, num=2; hold `dump_ready`=0 for 5 cycles during the first HOLD.
  - `dump_data` and `dump_addr` (0x0020) stay stable and no `mem_enb` occurs in that window.
  - The second word follows 3 cycles after release; `done` arrives 5 cycles later than in the unstalled case.
- **Zero length:** num=0 → `done` in T+1, `busy` stays 0, `mem_enb` never asserts.
- **Wrap-around:** base=0x3FFE, num=3 → `mem_addrb` sequence 0x3FFE, 0x3FFF, 0x0000, with matching `dump_addr`; then `done`.
- **Ignored start and reset mid-dump:** pulse `start` again (base=0x0100) during the first HOLD of a 4-word dump at 0x0040 → the addresses stay 0x0040..0x0043. Then assert `rst` during a HOLD of a new dump → `dump_valid` drops asynchronously, there is no `done`, and state returns to IDLE.
